// File: rtl/mem_bus_pkg.sv
// Shared definitions for the requester-side memory bus controller:
// FSM state encoding, memory RW encoding and the default MFC timeout.
package mem_bus_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ASSERT  = 3'd2,
    RELEASE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for asynchronous status lines such as MFC.
// The first stage may go metastable; only the second stage is used downstream.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two back-to-back flops, both cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Requester-side bus controller: turns a clocked load/store request into the
// asynchronous memory's EN/RW/addr/data strobe protocol, waits on the
// synchronised MFC handshake, and reports done (and err on timeout).
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int TW      = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          rw,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_mfc
);

  state_t        state, state_next;
  logic [TW-1:0] cnt, cnt_next, cnt_inc;
  logic          cnt_hit;
  logic          tmo_flag, tmo_next;
  logic          accept, capture, en_next;
  logic          mfc_s;

  sync2 #(.W(1)) u_mfc_sync (
    .clk   (clk),
    .reset (reset),
    .d     (mem_mfc),
    .q     (mfc_s)
  );

  assign cnt_inc = (cnt >= TW'(TIMEOUT)) ? cnt : cnt + 1'b1;
  assign cnt_hit = (cnt >= TW'(TIMEOUT - 1));

  // Next-state, wait counter and timeout flag, plus the accept/capture strobes.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    tmo_next   = tmo_flag;
    accept     = 1'b0;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          accept     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        if (!mfc_s) begin
          cnt_next   = '0;
          state_next = ASSERT;
        end else if (cnt_hit) begin
          cnt_next   = cnt_inc;
          tmo_next   = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      ASSERT: begin
        if (mfc_s) begin
          capture    = (mem_rw == RW_READ);
          cnt_next   = '0;
          state_next = RELEASE;
        end else if (cnt_hit) begin
          cnt_next   = cnt_inc;
          tmo_next   = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      RELEASE: begin
        if (!mfc_s) begin
          state_next = DONE;
        end else if (cnt_hit) begin
          cnt_next   = cnt_inc;
          tmo_next   = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      DONE: begin
        cnt_next   = '0;
        tmo_next   = 1'b0;
        state_next = IDLE;
      end
      default: begin
        cnt_next   = '0;
        tmo_next   = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // EN comes from a flop so the asynchronous memory never sees a decode glitch.
  assign en_next = (state_next == ASSERT);

  // FSM state, counter and timeout flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      tmo_flag <= 1'b0;
      mem_en   <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      tmo_flag <= tmo_next;
      mem_en   <= en_next;
    end
  end

  // Request latch (held until the next acceptance) and read-data capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      if (accept) begin
        mem_rw    <= rw;
        mem_addr  <= addr;
        mem_wdata <= wdata;
      end
      if (capture) begin
        rdata <= mem_rdata;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign err  = (state == DONE) && tmo_flag;

endmodule
